// File: rtl/ring_phase_monitor.sv
// Phase monitor for an 8-bit one-hot ring counter.
// Tracks phase, validates each step, counts revolutions, and requests a resync after repeated faults.
module ring_phase_monitor #(
  parameter int REV_WIDTH = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [7:0]           ring,
  input  logic                 resync_ack,
  input  logic                 err_clear,
  output logic [2:0]           phase,
  output logic                 phase_valid,
  output logic                 wrap,
  output logic [REV_WIDTH-1:0] rev_count,
  output logic                 error,
  output logic                 resync_req
);

  typedef enum logic [1:0] {IDLE, TRACK, REQ} state_t;

  localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

  state_t               state_q, state_d;
  logic [7:0]           prev_ring_q, prev_ring_d;
  logic                 prev_en_q, prev_en_d;
  logic [3:0]           err_cnt_q, err_cnt_d;
  logic [2:0]           phase_q, phase_d;
  logic                 phase_valid_q, phase_valid_d;
  logic                 wrap_q, wrap_d;
  logic [REV_WIDTH-1:0] rev_count_q, rev_count_d;
  logic                 error_q, error_d;
  logic                 resync_req_q, resync_req_d;

  logic       sample_legal;
  logic [2:0] sample_index;
  logic [7:0] expected_ring;
  logic       track_good;
  logic       track_bad;
  logic       wrap_step;
  logic [3:0] err_cnt_inc;

  // Sample classification: one-hot test, encoder, and the step expected from the previous sample.
  always_comb begin
    sample_legal  = (ring != 8'h00) && ((ring & (ring - 8'd1)) == 8'h00);
    sample_index  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ring[i]) sample_index = 3'(i);
    end
    expected_ring = prev_en_q ? {prev_ring_q[6:0], prev_ring_q[7]} : prev_ring_q;
    track_good    = (state_q == TRACK) && sample_legal && (ring == expected_ring);
    track_bad     = (state_q == TRACK) && !(sample_legal && (ring == expected_ring));
    wrap_step     = track_good && prev_en_q && (prev_ring_q == 8'h80) && (ring == 8'h01);
    err_cnt_inc   = err_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_legal) state_d = TRACK;
      TRACK:   if (track_bad && (err_cnt_inc == ERR_LIMIT_C)) state_d = REQ;
      REQ:     if (resync_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error flag set takes priority over a simultaneous clear; resync leaves it untouched.
  always_comb begin
    prev_ring_d   = ring;
    prev_en_d     = enable;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = wrap_step;
    rev_count_d   = rev_count_q + {{(REV_WIDTH-1){1'b0}}, wrap_step};
    err_cnt_d     = err_cnt_q;
    error_d       = track_bad | (error_q & ~err_clear);
    resync_req_d  = (state_d == REQ);
    unique case (state_q)
      IDLE: begin
        if (sample_legal) phase_d = sample_index;
      end
      TRACK: begin
        if (track_good) begin
          phase_d       = sample_index;
          phase_valid_d = 1'b1;
          err_cnt_d     = 4'd0;
        end else begin
          err_cnt_d = err_cnt_inc;
        end
      end
      REQ: begin
        if (resync_ack) err_cnt_d = 4'd0;
      end
      default: err_cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_ring_q   <= 8'h00;
      prev_en_q     <= 1'b0;
      err_cnt_q     <= 4'd0;
      phase_q       <= 3'd0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      rev_count_q   <= '0;
      error_q       <= 1'b0;
      resync_req_q  <= 1'b0;
    end else begin
      prev_ring_q   <= prev_ring_d;
      prev_en_q     <= prev_en_d;
      err_cnt_q     <= err_cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
      rev_count_q   <= rev_count_d;
      error_q       <= error_d;
      resync_req_q  <= resync_req_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;
  assign rev_count   = rev_count_q;
  assign error       = error_q;
  assign resync_req  = resync_req_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: a rule-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ring_phase_monitor;

  localparam int REV_W   = 2;
  localparam int ERR_LIM = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [7:0]       ring;
  logic             resync_ack;
  logic             err_clear;
  logic [2:0]       phase;
  logic             phase_valid;
  logic             wrap;
  logic [REV_W-1:0] rev_count;
  logic             error;
  logic             resync_req;

  int tests_run = 0;
  int tests_failed = 0;

  ring_phase_monitor #(.REV_WIDTH(REV_W), .ERR_LIMIT(ERR_LIM)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .ring(ring),
    .resync_ack(resync_ack), .err_clear(err_clear), .phase(phase),
    .phase_valid(phase_valid), .wrap(wrap), .rev_count(rev_count),
    .error(error), .resync_req(resync_req)
  );

  always #5 clock = ~clock;

  // Reference model state, described in terms of behaviour rather than encoding.
  logic [7:0] m_prev_ring;
  logic       m_prev_en;
  bit         m_tracking, m_requesting;
  int         m_bad_run;
  int         m_phase;
  bit         m_pv, m_wrap, m_error;
  int         m_revs;

  function automatic int index_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  always @(posedge clock or negedge reset_n) begin : model_step
    logic [7:0] want;
    bit legal, bad;
    if (!reset_n) begin
      m_prev_ring = 8'h00; m_prev_en = 1'b0;
      m_tracking = 0; m_requesting = 0; m_bad_run = 0;
      m_phase = 0; m_pv = 0; m_wrap = 0; m_error = 0; m_revs = 0;
    end else begin
      legal = ($countones(ring) == 1);
      bad = 0;
      m_wrap = 0;
      m_pv = 0;
      if (m_requesting) begin
        if (resync_ack) begin m_requesting = 0; m_bad_run = 0; end
      end else if (!m_tracking) begin
        if (legal) begin m_phase = index_of(ring); m_tracking = 1; end
      end else begin
        want = m_prev_en ? rotl(m_prev_ring) : m_prev_ring;
        if (legal && ring == want) begin
          m_phase = index_of(ring);
          m_pv = 1;
          m_bad_run = 0;
          if (m_prev_en && m_prev_ring == 8'h80 && ring == 8'h01) begin
            m_wrap = 1;
            m_revs = (m_revs + 1) % (1 << REV_W);
          end
        end else begin
          bad = 1;
          m_bad_run++;
          if (m_bad_run == ERR_LIM) begin m_tracking = 0; m_requesting = 1; end
        end
      end
      if (bad) m_error = 1;
      else if (err_clear) m_error = 0;
      m_prev_ring = ring;
      m_prev_en = enable;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      check_output("model.phase", 32'(phase), 32'(m_phase));
      check_output("model.phase_valid", 32'(phase_valid), 32'(m_pv));
      check_output("model.wrap", 32'(wrap), 32'(m_wrap));
      check_output("model.rev_count", 32'(rev_count), 32'(m_revs));
      check_output("model.error", 32'(error), 32'(m_error));
      check_output("model.resync_req", 32'(resync_req), 32'(m_requesting));
    end
  end

  task automatic apply_stimulus(input logic [7:0] r, input logic en, input logic ack, input logic clr);
    ring = r; enable = en; resync_ack = ack; err_clear = clr;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] r;
    int wraps;
    int rev_seq [4];
    rev_seq = '{1, 2, 3, 0};

    reset_n = 1'b0; enable = 1'b0; ring = 8'h00; resync_ack = 1'b0; err_clear = 1'b0;
    repeat (2) @(negedge clock);
    check_output("reset.phase", 32'(phase), 0);
    check_output("reset.phase_valid", 32'(phase_valid), 0);
    check_output("reset.rev_count", 32'(rev_count), 0);
    check_output("reset.error", 32'(error), 0);
    check_output("reset.resync_req", 32'(resync_req), 0);
    reset_n = 1'b1;

    // Clean run: nine rotating samples starting at 8'h01.
    r = 8'h01; wraps = 0;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(r, 1'b1, 1'b0, 1'b0);
      check_output("clean.phase", 32'(phase), 32'(i % 8));
      check_output("clean.phase_valid", 32'(phase_valid), (i >= 1) ? 1 : 0);
      wraps += int'(wrap);
      r = rotl(r);
    end
    check_output("clean.wraps", 32'(wraps), 1);
    check_output("clean.rev_count", 32'(rev_count), 1);
    check_output("clean.error", 32'(error), 0);

    // Hold at 8'h08 with enable low.
    apply_stimulus(8'h02, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h04, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(8'h08, 1'b0, 1'b0, 1'b0);
      check_output("hold.phase", 32'(phase), 3);
      check_output("hold.error", 32'(error), 0);
      check_output("hold.wrap", 32'(wrap), 0);
    end

    // Single glitch; the sample after it is checked against the glitch value too.
    apply_stimulus(8'h08, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h0C, 1'b1, 1'b0, 1'b0);
    check_output("glitch.phase_valid", 32'(phase_valid), 0);
    check_output("glitch.phase_hold", 32'(phase), 3);
    check_output("glitch.error", 32'(error), 1);
    apply_stimulus(8'h20, 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'h40, 1'b1, 1'b0, 1'b0);
    check_output("glitch.resume_phase", 32'(phase), 6);
    check_output("glitch.resync_req", 32'(resync_req), 0);
    apply_stimulus(8'h80, 1'b1, 1'b0, 1'b1);
    check_output("glitch.err_clear", 32'(error), 0);

    // Persistent fault leading to a resync request.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
      check_output("fault.resync_req", 32'(resync_req), (i == 2) ? 1 : 0);
    end
    apply_stimulus(8'h01, 1'b0, 1'b1, 1'b0);
    check_output("fault.req_drop", 32'(resync_req), 0);
    check_output("fault.error_sticky", 32'(error), 1);
    apply_stimulus(8'h01, 1'b1, 1'b0, 1'b0);
    check_output("fault.idle_phase", 32'(phase), 0);
    check_output("fault.idle_valid", 32'(phase_valid), 0);
    apply_stimulus(8'h02, 1'b1, 1'b1, 1'b1);
    check_output("fault.track_phase", 32'(phase), 1);
    check_output("fault.track_valid", 32'(phase_valid), 1);
    check_output("fault.stray_ack", 32'(resync_req), 0);

    // Revolution counter wrap from a fresh reset.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    r = 8'h01; wraps = 0;
    for (int i = 0; i < 33; i++) begin
      apply_stimulus(r, 1'b1, 1'b0, 1'b0);
      if (wrap) begin
        check_output("revwrap.rev_count", 32'(rev_count), 32'(rev_seq[wraps % 4]));
        wraps++;
      end
      r = rotl(r);
    end
    check_output("revwrap.wraps", 32'(wraps), 4);

    // One more revolution, then a fault burst and an asynchronous reset inside REQ.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(r, 1'b1, 1'b0, 1'b0);
      r = rotl(r);
    end
    check_output("midreq.rev_before", 32'(rev_count), 1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 1'b1, 1'b0, 1'b0);
    check_output("midreq.req_before", 32'(resync_req), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midreq.resync_req", 32'(resync_req), 0);
    check_output("midreq.error", 32'(error), 0);
    check_output("midreq.rev_count", 32'(rev_count), 0);
    check_output("midreq.phase", 32'(phase), 0);
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus(8'h04, 1'b1, 1'b0, 1'b0);
    check_output("midreq.idle_after", 32'(phase_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
